// File: rtl/fuzzy_pkg.sv
// Shared types for the rule-firing sequencer: rule count, FSM states and
// the mapping from a rule index k = 3*i + j to its (i, j) antecedent pair.
package fuzzy_pkg;

  localparam int unsigned N_RULES = 9;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StEmit,
    StFinish
  } state_e;

  typedef struct packed {
    logic [1:0] i;
    logic [1:0] j;
  } rule_ij_t;

  function automatic rule_ij_t rule_map(input logic [3:0] k);
    rule_ij_t m;
    case (k)
      4'd0:    m = {2'd0, 2'd0};
      4'd1:    m = {2'd0, 2'd1};
      4'd2:    m = {2'd0, 2'd2};
      4'd3:    m = {2'd1, 2'd0};
      4'd4:    m = {2'd1, 2'd1};
      4'd5:    m = {2'd1, 2'd2};
      4'd6:    m = {2'd2, 2'd0};
      4'd7:    m = {2'd2, 2'd1};
      4'd8:    m = {2'd2, 2'd2};
      default: m = {2'd0, 2'd0};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/min_par.sv
// Interval min pair: UP = min of uppers, LOW = min of lowers, LOW clamped to UP.
module min_par #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_up,
  input  logic [W-1:0] a_low,
  input  logic [W-1:0] b_up,
  input  logic [W-1:0] b_low,
  output logic [W-1:0] up,
  output logic [W-1:0] low
);

  logic [W-1:0] up_min;
  logic [W-1:0] low_min;

  always_comb begin
    up_min  = (a_up < b_up) ? a_up : b_up;
    low_min = (a_low < b_low) ? a_low : b_low;
    up      = up_min;
    low     = (low_min > up_min) ? up_min : low_min;
  end

endmodule

// File: rtl/rule_firing_seq.sv
// Sequences the 9 rules of a 3x3 interval type-2 fuzzy rule base over a
// captured sample, emitting one firing-strength pair per rule with Valid/Ready.
module rule_firing_seq
  import fuzzy_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter bit          EMIT_ZERO = 1'b1
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           Start,
  input  logic [6*W-1:0] Pert_UP,
  input  logic [6*W-1:0] Pert_LOW,
  input  logic [5:0]     Ativo_UP,
  input  logic           Ready,
  output logic           Valid,
  output logic [3:0]     Regra,
  output logic [W-1:0]   Disparo_UP,
  output logic [W-1:0]   Disparo_LOW,
  output logic           Busy,
  output logic           Done,
  output logic [3:0]     Num_Ativas
);

  state_e         state_q, state_d;
  logic [6*W-1:0] snap_up_q, snap_up_d;
  logic [6*W-1:0] snap_low_q, snap_low_d;
  logic [5:0]     snap_act_q, snap_act_d;
  logic [3:0]     rule_q, rule_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   disp_up_q, disp_up_d;
  logic [W-1:0]   disp_low_q, disp_low_d;
  logic [3:0]     num_q, num_d;

  logic [3:0]     k_sel;
  rule_ij_t       ij;
  int unsigned    sh_a, sh_b;
  logic           rule_act;
  logic [W-1:0]   a_up, a_low, b_up, b_low;
  logic [W-1:0]   min_up, min_low;
  logic           load;

  // Rule fetched for the next presentation: rule 0 from CAPTURE, else successor.
  always_comb begin
    k_sel    = (state_q == StCapture) ? 4'd0 : rule_q + 4'd1;
    ij       = rule_map(k_sel);
    sh_a     = (5 - int'(ij.i)) * W;
    sh_b     = (2 - int'(ij.j)) * W;
    a_up     = snap_up_q[sh_a +: W];
    a_low    = snap_low_q[sh_a +: W];
    b_up     = snap_up_q[sh_b +: W];
    b_low    = snap_low_q[sh_b +: W];
    rule_act = snap_act_q[3'd5 - {1'b0, ij.i}] & snap_act_q[3'd2 - {1'b0, ij.j}];
  end

  min_par #(
    .W(W)
  ) u_min_par (
    .a_up (a_up),
    .a_low(a_low),
    .b_up (b_up),
    .b_low(b_low),
    .up   (min_up),
    .low  (min_low)
  );

  always_comb begin
    state_d    = state_q;
    snap_up_d  = snap_up_q;
    snap_low_d = snap_low_q;
    snap_act_d = snap_act_q;
    rule_d     = rule_q;
    valid_d    = valid_q;
    disp_up_d  = disp_up_q;
    disp_low_d = disp_low_q;
    num_d      = num_q;
    load       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          snap_up_d  = Pert_UP;
          snap_low_d = Pert_LOW;
          snap_act_d = Ativo_UP;
          num_d      = 4'd0;
          state_d    = StCapture;
        end
      end
      StCapture: begin
        load    = 1'b1;
        state_d = StEmit;
      end
      StEmit: begin
        // A skipped (Valid=0) rule advances without waiting for Ready.
        if (!valid_q || Ready) begin
          if (valid_q && (disp_up_q != '0) && (num_q < 4'(N_RULES))) begin
            num_d = num_q + 4'd1;
          end
          if (rule_q == 4'(N_RULES - 1)) begin
            valid_d = 1'b0;
            state_d = StFinish;
          end else begin
            load = 1'b1;
          end
        end
      end
      StFinish: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      rule_d     = k_sel;
      valid_d    = rule_act | EMIT_ZERO;
      disp_up_d  = rule_act ? min_up : '0;
      disp_low_d = rule_act ? min_low : '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StIdle;
      snap_up_q  <= '0;
      snap_low_q <= '0;
      snap_act_q <= '0;
      rule_q     <= '0;
      valid_q    <= 1'b0;
      disp_up_q  <= '0;
      disp_low_q <= '0;
      num_q      <= '0;
    end else begin
      state_q    <= state_d;
      snap_up_q  <= snap_up_d;
      snap_low_q <= snap_low_d;
      snap_act_q <= snap_act_d;
      rule_q     <= rule_d;
      valid_q    <= valid_d;
      disp_up_q  <= disp_up_d;
      disp_low_q <= disp_low_d;
      num_q      <= num_d;
    end
  end

  assign Valid       = valid_q;
  assign Regra       = rule_q;
  assign Disparo_UP  = disp_up_q;
  assign Disparo_LOW = disp_low_q;
  assign Busy        = (state_q != StIdle);
  assign Done        = (state_q == StFinish);
  assign Num_Ativas  = num_q;

endmodule

// File: tb/tb_rule_firing_seq.sv
// Randomized bench for rule_firing_seq: one instance per EMIT_ZERO setting,
// each pass checked against a rule list computed from k = 3*i + j arithmetic.
module tb_rule_firing_seq;

  localparam int W = 8;

  typedef struct {
    int k;
    int up;
    int low;
  } rule_t;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic [6*W-1:0] pert_up = '0;
  logic [6*W-1:0] pert_low = '0;
  logic [5:0]     ativo = '0;
  logic           start1 = 1'b0, start0 = 1'b0;
  logic           ready1 = 1'b0, ready0 = 1'b0;

  logic           v1, v0, b1, b0, d1, d0;
  logic [3:0]     r1, r0, n1, n0;
  logic [W-1:0]   u1, u0, l1, l0;

  bit             sel = 1'b1;
  logic           o_valid, o_busy, o_done;
  logic [3:0]     o_regra, o_num;
  logic [W-1:0]   o_up, o_low;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  rule_firing_seq #(.W(W), .EMIT_ZERO(1'b1)) dut1 (
    .CLK(CLK), .RESET(RESET), .Start(start1), .Pert_UP(pert_up), .Pert_LOW(pert_low),
    .Ativo_UP(ativo), .Ready(ready1), .Valid(v1), .Regra(r1), .Disparo_UP(u1),
    .Disparo_LOW(l1), .Busy(b1), .Done(d1), .Num_Ativas(n1)
  );

  rule_firing_seq #(.W(W), .EMIT_ZERO(1'b0)) dut0 (
    .CLK(CLK), .RESET(RESET), .Start(start0), .Pert_UP(pert_up), .Pert_LOW(pert_low),
    .Ativo_UP(ativo), .Ready(ready0), .Valid(v0), .Regra(r0), .Disparo_UP(u0),
    .Disparo_LOW(l0), .Busy(b0), .Done(d0), .Num_Ativas(n0)
  );

  always_comb begin
    o_valid = sel ? v1 : v0;
    o_busy  = sel ? b1 : b0;
    o_done  = sel ? d1 : d0;
    o_regra = sel ? r1 : r0;
    o_num   = sel ? n1 : n0;
    o_up    = sel ? u1 : u0;
    o_low   = sel ? l1 : l0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int fou(input logic [6*W-1:0] v, input int n);
    return int'((v >> ((6 - n) * W)) & 48'hFF);
  endfunction

  task automatic set_fou(input int n, input int up, input int low);
    pert_up[(6-n)*W +: W]  = W'(up);
    pert_low[(6-n)*W +: W] = W'(low);
  endtask

  task automatic randomize_inputs();
    for (int n = 1; n <= 6; n++) begin
      set_fou(n, $urandom_range(255), $urandom_range(255));
    end
    ativo = 6'($urandom_range(63));
  endtask

  task automatic drive_start(input bit s, input logic val);
    if (s) start1 = val;
    else   start0 = val;
  endtask

  task automatic drive_ready(input bit s, input logic val);
    if (s) ready1 = val;
    else   ready0 = val;
  endtask

  // mode 0: Ready always 1; mode 1: random Ready, inputs scrambled mid-pass,
  // Start possibly held; mode 2: Ready held 0 for 5 cycles on rule 3.
  task automatic run_pass(input bit s, input int mode);
    rule_t q[$];
    rule_t r;
    int    exp_num = 0;
    int    cyc, stalls = 0, hold3 = 0;
    bit    done = 0, hold_start;
    logic  rdy;

    for (int k = 0; k < 9; k++) begin
      int i = k / 3;
      int j = k % 3;
      bit act = ativo[5 - i] && ativo[2 - j];
      int ua = fou(pert_up, i + 1), ub = fou(pert_up, j + 4);
      int la = fou(pert_low, i + 1), lb = fou(pert_low, j + 4);
      r.k   = k;
      r.up  = act ? ((ua < ub) ? ua : ub) : 0;
      r.low = act ? ((la < lb) ? la : lb) : 0;
      if (r.low > r.up) r.low = r.up;
      if (s || act) begin
        q.push_back(r);
        if (r.up != 0) exp_num++;
      end
    end
    if (exp_num > 9) exp_num = 9;

    sel = s;
    hold_start = (mode == 1) && ($urandom_range(1) == 1);
    @(negedge CLK);
    drive_start(s, 1'b1);
    drive_ready(s, 1'b1);
    @(negedge CLK);
    if (!hold_start) drive_start(s, 1'b0);
    cyc = 1;
    check("capture_busy", 32'(o_busy), 1);
    check("capture_valid", 32'(o_valid), 0);

    while (!done && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (mode == 1) randomize_inputs();
      if (o_done) begin
        done = 1;
        check("done_cycle", cyc, 11 + stalls);
        check("rules_left", q.size(), 0);
        check("num_ativas", 32'(o_num), exp_num);
        check("done_valid", 32'(o_valid), 0);
        drive_start(s, 1'b0);
      end else begin
        check("emit_busy", 32'(o_busy), 1);
        if (o_valid) begin
          if (q.size() == 0) begin
            check("extra_rule", 1, 0);
            rdy = 1'b1;
          end else begin
            check("regra", 32'(o_regra), q[0].k);
            check("disparo_up", 32'(o_up), q[0].up);
            check("disparo_low", 32'(o_low), q[0].low);
            if (mode == 1) rdy = ($urandom_range(3) != 0);
            else if (mode == 2 && o_regra == 4'd3 && hold3 < 5) begin
              rdy = 1'b0;
              hold3++;
            end else rdy = 1'b1;
            if (rdy) void'(q.pop_front());
            else stalls++;
          end
        end else begin
          rdy = 1'($urandom_range(1));
        end
        drive_ready(s, rdy);
      end
    end
    if (!done) check("done_timeout", 0, 1);
    @(negedge CLK);
    check("idle_busy", 32'(o_busy), 0);
    check("idle_done", 32'(o_done), 0);
  endtask

  task automatic load_reference();
    set_fou(1, 200, 180);
    set_fou(2, 60, 40);
    set_fou(3, 0, 0);
    set_fou(4, 150, 130);
    set_fou(5, 90, 70);
    set_fou(6, 0, 0);
    ativo = 6'b110110;
  endtask

  initial begin
    int guard;

    #12;
    check("rst_valid", 32'(v1), 0);
    check("rst_busy", 32'(b1), 0);
    check("rst_done", 32'(d1), 0);
    check("rst_num", 32'(n1), 0);
    check("rst_regra", 32'(r1), 0);
    @(negedge CLK);
    RESET = 1'b0;

    load_reference();
    run_pass(1'b1, 0);
    run_pass(1'b0, 0);
    run_pass(1'b1, 2);

    // Clamp: LOW1 above UP1
    set_fou(1, 50, 80);
    set_fou(4, 100, 100);
    ativo = 6'b100100;
    run_pass(1'b1, 0);
    run_pass(1'b0, 0);

    // Reset while rule 5 is presented
    load_reference();
    sel = 1'b1;
    @(negedge CLK);
    start1 = 1'b1;
    ready1 = 1'b1;
    @(negedge CLK);
    start1 = 1'b0;
    guard = 0;
    while (!(v1 && r1 == 4'd5) && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    check("reach_rule5", 32'(r1), 5);
    RESET = 1'b1;
    #1;
    check("abort_valid", 32'(v1), 0);
    check("abort_regra", 32'(r1), 0);
    check("abort_up", 32'(u1), 0);
    check("abort_low", 32'(l1), 0);
    check("abort_busy", 32'(b1), 0);
    check("abort_num", 32'(n1), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("abort_no_done", 32'(d1), 0);
    end
    RESET = 1'b0;
    run_pass(1'b1, 0);

    for (int p = 0; p < 12; p++) begin
      randomize_inputs();
      run_pass(1'(p % 2), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
